// File: rtl/hilo_unit.sv
// HI/LO register file with single-cycle multiply and a 32-step restoring divider.
// Divides hold the pipeline through stall_req until the write-back cycle.
package hilo_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } Oper_t;
endpackage

module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  Oper_t       op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] result,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   quo, rem, dvs;
  logic          q_neg, r_neg, dvz;

  logic        is_div, is_sdiv, start, fire;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] shifted, diff;
  logic [31:0] quo_step, rem_step, hi_div, lo_div;
  logic [63:0] prod_s, prod_u;

  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign is_sdiv = (op == OP_DIV);
  assign start   = (state == S_IDLE) && valid && !flush && is_div;
  assign fire    = valid && !flush && !stall_req;

  assign rs_mag = (is_sdiv && rs_data[31]) ? 32'd0 - rs_data : rs_data;
  assign rt_mag = (is_sdiv && rt_data[31]) ? 32'd0 - rt_data : rt_data;

  // Restoring step: shift the next dividend bit into the partial remainder,
  // keep the subtraction only if it did not go negative.
  assign shifted  = {rem, quo[31]};
  assign diff     = shifted - {1'b0, dvs};
  assign rem_step = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_step = {quo[30:0], ~diff[32]};

  // With a zero divisor the remainder path reproduces rs_data exactly.
  assign hi_div = r_neg ? 32'd0 - rem : rem;
  assign lo_div = dvz ? '1 : (q_neg ? 32'd0 - quo : quo);

  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_BUSY;
          stall_req = 1'b1;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          stall_req = 1'b1;
          if (cnt == LAST) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    result = '0;
    if (valid) begin
      unique case (op)
        OP_MFHI: result = hi;
        OP_MFLO: result = lo;
        default: result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dvz   <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      quo   <= rs_mag;
      rem   <= '0;
      dvs   <= rt_mag;
      q_neg <= is_sdiv && (rs_data[31] ^ rt_data[31]);
      r_neg <= is_sdiv && rs_data[31];
      dvz   <= (rt_data == 32'd0);
    end else if (state == S_BUSY && !flush) begin
      cnt <= cnt + 1'b1;
      quo <= quo_step;
      rem <= rem_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (fire) begin
      if (state == S_DONE) begin
        hi <= hi_div;
        lo <= lo_div;
      end else begin
        unique case (op)
          OP_MTHI:  hi <= rs_data;
          OP_MTLO:  lo <= rs_data;
          OP_MULT:  {hi, lo} <= prod_s;
          OP_MULTU: {hi, lo} <= prod_u;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: HI/LO moves, multiplies, divides, flush and reset abort.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  Oper_t       op = OP_NOP;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic [31:0] result, hi, lo;
  logic        stall_req;

  int checks = 0;
  int failures = 0;
  int n;

  hilo_unit #(.DIV_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .result(result), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic v, input Oper_t o, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    valid = v; op = o; rs_data = a; rt_data = b; flush = f;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Issues a divide, counts stalled cycles (bounded), lets DONE commit, then idles.
  task automatic do_div(input Oper_t o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    drive(1'b1, o, a, b, 1'b0);
    stalls = 0;
    while (stall_req === 1'b1 && stalls < 40) begin
      stalls++;
      next();
      #1;
    end
    next();
    drive(1'b0, OP_NOP, '0, '0, 1'b0);
  endtask

  initial begin
    // Reset values
    drive(1'b1, OP_MFLO, '0, '0, 1'b0);
    next();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_stall", {31'd0, stall_req}, 32'h0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;

    // MTHI then MFHI
    drive(1'b1, OP_MTHI, 32'h12345678, '0, 1'b0);
    chk("mthi_stall", {31'd0, stall_req}, 32'h0);
    next();
    drive(1'b1, OP_MFHI, '0, '0, 1'b0);
    chk("mfhi_result", result, 32'h12345678);
    chk("mthi_lo_kept", lo, 32'h0);

    // MULT / MULTU -2 * 3
    next();
    drive(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_result_zero", result, 32'h0);
    next();
    drive(1'b1, OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    next();
    drive(1'b0, OP_MFHI, '0, '0, 1'b0);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    chk("invalid_result_zero", result, 32'h0);
    next();

    // Signed divide -7 / 2
    do_div(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
    chk("div_stall_cycles", n, 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_idle_stall", {31'd0, stall_req}, 32'h0);
    next();

    // Divide by zero
    do_div(OP_DIVU, 32'd100, 32'd0, n);
    chk("divz_stall_cycles", n, 32'd33);
    chk("divz_lo", lo, 32'hFFFFFFFF);
    chk("divz_hi", hi, 32'd100);
    next();

    // Overflow case
    do_div(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    chk("ovf_stall_cycles", n, 32'd33);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    next();

    // Flush at BUSY cycle 10
    drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (11) next();
    chk("flush_busy_stall", {31'd0, stall_req}, 32'h1);
    drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b1);
    chk("flush_stall_drop", {31'd0, stall_req}, 32'h0);
    next();
    drive(1'b0, OP_NOP, '0, '0, 1'b0);
    chk("flush_idle_stall", {31'd0, stall_req}, 32'h0);
    chk("flush_hi_kept", hi, 32'h0);
    chk("flush_lo_kept", lo, 32'h80000000);
    next();
    drive(1'b1, OP_MFLO, '0, '0, 1'b0);
    chk("flush_mflo", result, 32'h80000000);
    next();

    // Load nonzero HI/LO so the reset abort is visible
    drive(1'b1, OP_MTHI, 32'hAAAA5555, '0, 1'b0);
    next();
    drive(1'b1, OP_MTLO, 32'h5555AAAA, '0, 1'b0);
    next();
    drive(1'b0, OP_NOP, '0, '0, 1'b0);
    chk("mt_hi", hi, 32'hAAAA5555);
    chk("mt_lo", lo, 32'h5555AAAA);
    next();

    // Reset at BUSY cycle 20
    drive(1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (21) next();
    chk("rstmid_busy_stall", {31'd0, stall_req}, 32'h1);
    rst_n = 1'b0;
    drive(1'b0, OP_NOP, '0, '0, 1'b0);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    chk("rstmid_stall", {31'd0, stall_req}, 32'h0);
    next();
    rst_n = 1'b1;
    next();

    do_div(OP_DIVU, 32'd9, 32'd3, n);
    chk("post_rst_stall_cycles", n, 32'd33);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
